// File: rtl/buffer_pkg.sv
// Shared sizing helpers, default geometry and FSM encoding for the buffer loader.
package buffer_pkg;

  localparam int X_MAC_DEF    = 4;
  localparam int X_MESH_DEF   = 16;
  localparam int ADDR_LEN_DEF = 13;
  localparam int DATA_LEN_DEF = 32;

  function automatic int buffer_num(input int x_mac, input int x_mesh);
    return x_mac * x_mesh;
  endfunction

  // A single bank still needs a 1-bit select to keep port widths legal.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int addr_len, input int n);
    return addr_len + sel_w(n) + 1;
  endfunction

  localparam int BUFFER_NUM = buffer_num(X_MAC_DEF, X_MESH_DEF);
  localparam int SEL_W      = sel_w(BUFFER_NUM);
  localparam int CNT_W      = cnt_w(ADDR_LEN_DEF, BUFFER_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_loader_if.sv
// Control, input stream and bank-write bus of the buffer loader.
interface buffer_loader_if
  import buffer_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int NB       = BUFFER_NUM,
  parameter int CW       = CNT_W
);
  logic                     start;
  logic [ADDR_LEN-1:0]      base_addr;
  logic [CW-1:0]            word_cnt;
  logic                     s_valid;
  logic [DATA_LEN-1:0]      s_data;
  logic                     s_ready;
  logic [NB*DATA_LEN-1:0]   dina;
  logic [NB*ADDR_LEN-1:0]   addra;
  logic [NB-1:0]            wea;
  logic                     busy;
  logic                     done;
  logic                     wrapped;

  modport master (
    output start, base_addr, word_cnt, s_valid, s_data,
    input  s_ready, dina, addra, wea, busy, done, wrapped
  );

  modport slave (
    input  start, base_addr, word_cnt, s_valid, s_data,
    output s_ready, dina, addra, wea, busy, done, wrapped
  );
endinterface

// File: rtl/bank_row_counter.sv
// Bank/row write pointer: bank steps every accepted word, row steps when the bank wraps.
module bank_row_counter #(
  parameter int NB       = 64,
  parameter int SEL_W    = 6,
  parameter int ADDR_LEN = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [ADDR_LEN-1:0] base,
  input  logic                adv,
  output logic [SEL_W-1:0]    bank,
  output logic [ADDR_LEN-1:0] row,
  output logic                wrap_evt
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NB - 1);

  logic bank_last;
  assign bank_last = (bank == LAST);
  // Row rolls over from all-ones to zero on this advance.
  assign wrap_evt  = adv && bank_last && (&row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
      row  <= '0;
    end else if (load) begin
      bank <= '0;
      row  <= base;
    end else if (adv) begin
      if (bank_last) begin
        bank <= '0;
        row  <= row + ADDR_LEN'(1);
      end else begin
        bank <= bank + SEL_W'(1);
      end
    end
  end
endmodule

// File: rtl/buffer_loader.sv
// Streams words round-robin into BUFFER_NUM bank RAMs; bank b = port*X_MAC + kernel.
module buffer_loader
  import buffer_pkg::*;
#(
  parameter int X_MAC    = X_MAC_DEF,
  parameter int X_MESH   = X_MESH_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  buffer_loader_if.slave  bus
);
  localparam int NB = buffer_num(X_MAC, X_MESH);
  localparam int SW = sel_w(NB);
  localparam int CW = cnt_w(ADDR_LEN, NB);

  state_t              state;
  logic [CW-1:0]       remain;
  logic [SW-1:0]       bank;
  logic [ADDR_LEN-1:0] row;
  logic                wrap_evt;
  logic                start_ok;
  logic                accept;

  assign start_ok    = (state == IDLE) && bus.start;
  assign accept      = (state == LOAD) && bus.s_valid;
  assign bus.s_ready = (state == LOAD);
  assign bus.busy    = (state != IDLE);

  bank_row_counter #(.NB(NB), .SEL_W(SW), .ADDR_LEN(ADDR_LEN)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .base     (bus.base_addr),
    .adv      (accept),
    .bank     (bank),
    .row      (row),
    .wrap_evt (wrap_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remain      <= '0;
      bus.wea     <= '0;
      bus.dina    <= '0;
      bus.addra   <= '0;
      bus.done    <= 1'b0;
      bus.wrapped <= 1'b0;
    end else begin
      bus.wea  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          remain      <= bus.word_cnt;
          bus.wrapped <= 1'b0;
          if (bus.word_cnt == '0) begin
            state    <= FLUSH;
            bus.done <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (bus.s_valid) begin
          bus.wea   <= {{(NB-1){1'b0}}, 1'b1} << bank;
          bus.dina  <= {NB{bus.s_data}};
          bus.addra <= {NB{row}};
          remain    <= remain - CW'(1);
          if (wrap_evt) bus.wrapped <= 1'b1;
          // done is launched with the last write so both land in the same cycle.
          if (remain == CW'(1)) begin
            state    <= FLUSH;
            bus.done <= 1'b1;
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buffer_loader.sv
// Directed vector bench for buffer_loader at default geometry (64 banks, 13-bit rows).
module tb_buffer_loader;
  import buffer_pkg::*;

  localparam int NB = BUFFER_NUM;

  typedef struct {
    logic [12:0] base;
    int          cnt;
    int          gap;     // percent of cycles with s_valid low
    int          inj;     // word index at which a stray start is pulsed, -1 none
    logic        exp_wr;  // wrapped expected at end of load
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  buffer_loader_if bus ();

  buffer_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mkdata(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Every slice must carry the same word/row; reports the first differing slice.
  task automatic chk_bus(input logic [31:0] d, input logic [12:0] r);
    logic [31:0] dd;
    logic [12:0] rr;
    dd = d;
    rr = r;
    for (int b = 0; b < NB; b++) begin
      if (bus.dina[b*32 +: 32] !== d && dd === d) dd = bus.dina[b*32 +: 32];
      if (bus.addra[b*13 +: 13] !== r && rr === r) rr = bus.addra[b*13 +: 13];
    end
    chk("dina", 64'(dd), 64'(d));
    chk("addra", 64'(rr), 64'(r));
  endtask

  task automatic run_load(input vec_t v, input int stop);
    int   k;
    int   cyc;
    logic vld;
    logic [12:0] exp_row;
    k   = 0;
    cyc = 0;
    bus.start     = 1'b1;
    bus.base_addr = v.base;
    bus.word_cnt  = CNT_W'(v.cnt);
    bus.s_valid   = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt  = '0;
    chk("busy_start", 64'(bus.busy), 64'd1);
    chk("wrapped_clr", 64'(bus.wrapped), 64'd0);
    while (k < stop && cyc < 2000) begin
      vld = (v.gap == 0) || ($urandom_range(99) >= v.gap);
      bus.s_valid = vld;
      bus.s_data  = mkdata(k);
      if (k == v.inj) begin
        bus.start     = 1'b1;
        bus.base_addr = 13'd3000;
        bus.word_cnt  = CNT_W'(5);
      end
      chk("s_ready", 64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (vld) begin
        exp_row = v.base + 13'(k / NB);
        chk("wea", 64'(bus.wea), 64'd1 << (k % NB));
        chk_bus(mkdata(k), exp_row);
        chk("done", 64'(bus.done), 64'(k == v.cnt - 1));
        k++;
      end else begin
        chk("wea_gap", 64'(bus.wea), 64'd0);
      end
      cyc++;
    end
    bus.s_valid = 1'b0;
    if (k < stop) chk("timeout", 64'(k), 64'(stop));
    if (stop == v.cnt) begin
      chk("s_ready_end", 64'(bus.s_ready), 64'd0);
      @(posedge clk); #1;
      chk("busy_end", 64'(bus.busy), 64'd0);
      chk("done_end", 64'(bus.done), 64'd0);
      chk("wea_end", 64'(bus.wea), 64'd0);
      chk("wrapped", 64'(bus.wrapped), 64'(v.exp_wr));
    end
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{13'd0,    128, 0,  -1, 1'b0};
    vecs[1] = '{13'd8191, 65,  0,  -1, 1'b1};
    vecs[2] = '{13'd100,  200, 30, -1, 1'b0};
    vecs[3] = '{13'd50,   20,  0,  5,  1'b0};
    vecs[4] = '{13'd8190, 130, 20, -1, 1'b1};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt  = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_wrapped", 64'(bus.wrapped), 64'd0);
    chk("rst_wea", 64'(bus.wea), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_load(vecs[i], vecs[i].cnt);

    // Reset in the middle of a 100-word load.
    rv = '{13'd0, 100, 0, -1, 1'b0};
    run_load(rv, 30);
    bus.s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wea", 64'(bus.wea), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.s_ready), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_dina", 64'(|bus.dina), 64'd0);
    chk("mid_rst_addra", 64'(|bus.addra), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_wea", 64'(bus.wea), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
    end
    bus.s_valid = 1'b0;
    rv = '{13'd0, 10, 0, -1, 1'b0};
    run_load(rv, 10);

    // Zero-length load: done and busy for exactly one cycle, no writes.
    bus.start     = 1'b1;
    bus.base_addr = 13'd5;
    bus.word_cnt  = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("zero_done", 64'(bus.done), 64'd1);
    chk("zero_busy", 64'(bus.busy), 64'd1);
    chk("zero_ready", 64'(bus.s_ready), 64'd0);
    chk("zero_wea", 64'(bus.wea), 64'd0);
    @(posedge clk); #1;
    chk("zero_done_end", 64'(bus.done), 64'd0);
    chk("zero_busy_end", 64'(bus.busy), 64'd0);
    chk("zero_wea_end", 64'(bus.wea), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_loader.md
BUFFER_LOADER -- requirements
Module: buffer_loader

Interface
REQ-001 Parameters SHALL be (name, default, meaning): X_MAC, 4, kernels per mesh port.
REQ-002 X_MESH, 16, mesh ports.
REQ-003 ADDR_LEN, 13, per-bank address width.
REQ-004 DATA_LEN, 32, word width.
REQ-005 Derived values SHALL be BUFFER_NUM = X_MAC*X_MESH, SEL_W = clog2(BUFFER_NUM), CNT_W = ADDR_LEN+SEL_W+1.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock; all logic rising-edge.
REQ-007 rst_n, in, 1, asynchronous active-low reset.
REQ-008 start, in, 1, one-cycle request to begin a load.
REQ-009 base_addr, in, ADDR_LEN, first row address, sampled on an accepted start.
REQ-010 word_cnt, in, CNT_W, words to load, sampled on an accepted start.
REQ-011 s_valid, in, 1, input word valid.
REQ-012 s_data, in, DATA_LEN, input word.
REQ-013 s_ready, out, 1, input word accepted when s_valid&&s_ready.
REQ-014 dina, out, BUFFER_NUM*DATA_LEN, bank write data.
REQ-015 addra, out, BUFFER_NUM*ADDR_LEN, bank write addresses.
REQ-016 wea, out, BUFFER_NUM, bank write enables.
REQ-017 busy, out, 1, load in progress.
REQ-018 done, out, 1, one-cycle completion pulse.
REQ-019 wrapped, out, 1, sticky flag set when the row address wraps past RAM depth; cleared on an accepted start.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD and FLUSH.
REQ-021 In IDLE, start SHALL be accepted: it latches base_addr/word_cnt, clears wrapped and goes to LOAD. If word_cnt==0 it goes to FLUSH instead.
REQ-022 start SHALL be ignored in LOAD and FLUSH.
REQ-023 s_ready SHALL be 1 only in LOAD; it is combinational from state only.
REQ-024 Accepted word k (0-based) SHALL target bank k mod BUFFER_NUM at row base_addr + k div BUFFER_NUM, taken modulo 2**ADDR_LEN.
- Bank index b maps to port=b div X_MAC, kernel=b mod X_MAC.
- Slice offset is b*DATA_LEN / b*ADDR_LEN.
REQ-025 Outputs SHALL be registered: a word accepted at edge t drives wea one-hot with dina/addra valid for exactly the cycle after edge t.
- All dina slices carry the word.
- All addra slices carry the row.
REQ-026 wea SHALL be all-zero in every cycle without a write; at most one bit is set per cycle.
REQ-027 Bank index SHALL wrap from BUFFER_NUM-1 to 0, incrementing the row.
REQ-028 A row increment from 2**ADDR_LEN-1 to 0 SHALL set wrapped; the write itself proceeds.
REQ-029 After the word_cnt-th word is accepted, the FSM SHALL go to FLUSH and deassert s_ready.
REQ-030 In FLUSH, done SHALL pulse for one cycle, coincident with the final wea cycle or one cycle after start when word_cnt==0; the FSM then returns to IDLE.
REQ-031 busy SHALL be 1 in LOAD and FLUSH, 0 in IDLE.
REQ-032 Throughput SHALL be one word per cycle with s_valid held high; s_valid gaps stall without writes.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE and set s_ready, busy, done, wrapped, wea to 0 and dina, addra, all counters to 0.
REQ-034 Reset asserted mid-load SHALL abandon the load; no write SHALL occur after release until a new start.
REQ-035 Deassertion SHALL be used synchronously to clk by the enclosing design.

Structure
REQ-036 BUFFER_NUM, SEL_W, CNT_W and the state encoding SHALL live in a shared package, buffer_pkg.
REQ-037 One sub-module, bank_row_counter, SHALL hold the bank/row counters and wrap detection; the FSM and output registers stay in buffer_loader.

Verification
REQ-038 Default params, base_addr=0, word_cnt=128, continuous valid, data=k: wea bit k%64 on at cycle k+1; row 0 for k<64, row 1 after; done with the last write; wrapped=0.
REQ-039 word_cnt=0: done exactly one cycle after start; no wea; busy high for one cycle.
REQ-040 base_addr=8191, word_cnt=65: the 65th word goes to bank 0, row 0; wrapped=1 after it.
REQ-041 Random s_valid gaps, word_cnt=200: exactly 200 writes in order, no wea during gaps.
REQ-042 start pulsed during LOAD with different base_addr: ignored; addresses unchanged.
REQ-043 rst_n low after 30 of 100 words: all outputs 0 immediately; no wea after release; a new start with word_cnt=10 completes normally.
